// File: rtl/md5_par_bus_if.sv
// Raspberry Pi parallel-bus slave for the md5 core: synchronises the bus pins,
// packs write beats into words through an RX FIFO and serialises result words on reads.
module md5_par_bus_if #(
  parameter int BUS_WIDTH   = 8,
  parameter int WORD_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_clk,
  input  logic                  bus_rnw,
  input  logic [BUS_WIDTH-1:0]  bus_data_in,
  output logic [BUS_WIDTH-1:0]  bus_data_out,
  output logic                  bus_data_oe,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  core_done,
  input  logic                  core_match,
  output logic                  bus_done,
  output logic                  bus_match,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int BEATS = WORD_WIDTH / BUS_WIDTH;
  localparam int WR_W  = $clog2(BEATS);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------- synchronisers
  logic [SYNC_STAGES-1:0]                clk_sync_q;
  logic [SYNC_STAGES-1:0]                rnw_sync_q;
  logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] data_sync_q;
  logic                                  clk_prev_q;
  logic                                  oe_q;

  logic                 clk_s;
  logic                 rnw_s;
  logic [BUS_WIDTH-1:0] data_s;
  logic                 strobe;
  logic                 rnw_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '0;
      rnw_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus_clk};
      rnw_sync_q  <= {rnw_sync_q[SYNC_STAGES-2:0], bus_rnw};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus_data_in};
      clk_prev_q  <= clk_s;
      oe_q        <= rnw_s;
    end
  end

  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign rnw_s       = rnw_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign strobe      = clk_s & ~clk_prev_q;
  // oe_q is rnw_s delayed by one cycle, so it doubles as the edge reference.
  assign rnw_rise    = rnw_s & ~oe_q;
  assign bus_data_oe = oe_q;

  // ---------------------------------------------------------------- write assembly
  logic [WR_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [WORD_WIDTH-1:0] word_next;
  logic                  push;

  assign word_next = {word_q[WORD_WIDTH-BUS_WIDTH-1:0], data_s};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    word_d   = word_q;
    push     = 1'b0;
    if (rnw_rise) begin
      wr_cnt_d = '0;
    end else if (strobe && !rnw_s) begin
      word_d = word_next;
      if (wr_cnt_q == WR_W'(BEATS - 1)) begin
        wr_cnt_d = '0;
        push     = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  overflow_q, overflow_d;

  assign full     = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign push_ok  = push & (~full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; occupancy lives in the pointers and
  // rx_data is gated by rx_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= word_next;
  end

  // ---------------------------------------------------------------- TX shifter
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  underflow_q, underflow_d;

  assign tx_ready     = (rd_cnt_q == '0);
  assign bus_data_out = shift_q[WORD_WIDTH-1 -: BUS_WIDTH];

  always_comb begin
    shift_d     = shift_q;
    rd_cnt_d    = rd_cnt_q;
    underflow_d = underflow_q;
    if (strobe && rnw_s) begin
      if (rd_cnt_q != '0) begin
        shift_d  = shift_q << BUS_WIDTH;
        rd_cnt_d = rd_cnt_q - 1'b1;
      end else begin
        underflow_d = 1'b1;
      end
    end
    if (tx_valid && tx_ready) begin
      shift_d  = tx_data;
      rd_cnt_d = CNT_W'(BEATS);
    end
  end

  // ---------------------------------------------------------------- state registers
  logic done_q, match_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      shift_q     <= '0;
      rd_cnt_q    <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      word_q      <= word_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      shift_q     <= shift_d;
      rd_cnt_q    <= rd_cnt_d;
      underflow_q <= underflow_d;
      done_q      <= core_done;
      match_q     <= core_match;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign bus_done  = done_q;
  assign bus_match = match_q;

endmodule

// File: tb/tb_md5_par_bus_if.sv
// Self-checking bench for md5_par_bus_if: 8/32 instance for the main paths and a
// 16/64 instance for the wide configuration, with queue-based scoreboards.
module tb_md5_par_bus_if;

  localparam int SYNC  = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8/32 instance
  logic        bus_clk, bus_rnw;
  logic [7:0]  bus_data_in, bus_data_out;
  logic        bus_data_oe;
  logic [31:0] rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic        core_done, core_match, bus_done, bus_match, overflow, underflow;

  // 16/64 instance
  logic        b2_clk, b2_rnw;
  logic [15:0] b2_din, b2_dout;
  logic        b2_oe;
  logic [63:0] rx2_data;
  logic        rx2_valid, rx2_ready, tx2_ready;
  logic        b2_done, b2_match, ovf2, udf2;

  md5_par_bus_if #(.BUS_WIDTH(8), .WORD_WIDTH(32), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .reset(reset), .bus_clk(bus_clk), .bus_rnw(bus_rnw),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .core_done(core_done), .core_match(core_match), .bus_done(bus_done), .bus_match(bus_match),
    .overflow(overflow), .underflow(underflow)
  );

  md5_par_bus_if #(.BUS_WIDTH(16), .WORD_WIDTH(64), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) u_dut16 (
    .clk(clk), .reset(reset), .bus_clk(b2_clk), .bus_rnw(b2_rnw),
    .bus_data_in(b2_din), .bus_data_out(b2_dout), .bus_data_oe(b2_oe),
    .rx_data(rx2_data), .rx_valid(rx2_valid), .rx_ready(rx2_ready),
    .tx_data(64'h0), .tx_valid(1'b0), .tx_ready(tx2_ready),
    .core_done(1'b0), .core_match(1'b0), .bus_done(b2_done), .bus_match(b2_match),
    .overflow(ovf2), .underflow(udf2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rx_sb[$];
  logic [63:0] rx64_sb[$];
  logic [7:0]  tx_sb[$];
  int          model_cnt;
  logic        model_ovf, model_udf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic rnw, input logic [7:0] d);
    @(negedge clk);
    bus_rnw     = rnw;
    bus_data_in = d;
    repeat (SYNC + 2) @(negedge clk);
    bus_clk = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    bus_clk = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) beat(1'b0, w[b*8 +: 8]);
    if (model_cnt < DEPTH) begin
      rx_sb.push_back(w);
      model_cnt++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic pop_one(input string tag);
    int waited = 0;
    while (!rx_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_valid) begin
      check({tag, "_timeout"}, {63'd0, rx_valid}, 64'd1);
    end else begin
      check(tag, {32'd0, rx_data}, {32'd0, rx_sb.pop_front()});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      model_cnt--;
    end
  endtask

  task automatic tx_load(input logic [31:0] w);
    @(negedge clk);
    check("load_ready_before", {63'd0, tx_ready}, 64'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int b = 3; b >= 0; b--) tx_sb.push_back(w[b*8 +: 8]);
    check("load_ready_after", {63'd0, tx_ready}, 64'd0);
  endtask

  task automatic read_beat(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    bus_rnw = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    if (tx_sb.size() != 0) begin
      exp = tx_sb.pop_front();
    end else begin
      exp       = 8'h00;
      model_udf = 1'b1;
    end
    check({tag, "_data"}, {56'd0, bus_data_out}, {56'd0, exp});
    check({tag, "_oe"}, {63'd0, bus_data_oe}, 64'd1);
    bus_clk = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    bus_clk = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    check({tag, "_udf"}, {63'd0, underflow}, {63'd0, model_udf});
  endtask

  task automatic beat16(input logic [15:0] d);
    @(negedge clk);
    b2_rnw = 1'b0;
    b2_din = d;
    repeat (SYNC + 2) @(negedge clk);
    b2_clk = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    b2_clk = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [63:0] w64;
    reset = 1'b1;
    bus_clk = 1'b0; bus_rnw = 1'b0; bus_data_in = '0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    core_done = 1'b0; core_match = 1'b0;
    b2_clk = 1'b0; b2_rnw = 1'b0; b2_din = '0; rx2_ready = 1'b0;
    model_cnt = 0; model_ovf = 1'b0; model_udf = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("rst_tx_ready", {63'd0, tx_ready}, 64'd1);
    check("rst_data_out", {56'd0, bus_data_out}, 64'd0);
    check("rst_oe", {63'd0, bus_data_oe}, 64'd0);
    check("rst_flags", {60'd0, overflow, underflow, bus_done, bus_match}, 64'd0);
    reset = 1'b0;

    // single word, then empty after pop
    write_word(32'h0123_4567);
    check("w1_valid", {63'd0, rx_valid}, 64'd1);
    pop_one("w1_data");
    check("w1_empty", {63'd0, rx_valid}, 64'd0);

    // fill to depth, then one more to overflow
    for (int i = 0; i < DEPTH; i++) write_word(32'h1000_0000 + i * 32'h0101_0101);
    check("fill_no_ovf", {63'd0, overflow}, 64'd0);
    write_word(32'hFFFF_0000);
    check("ovf_set", {63'd0, overflow}, {63'd0, model_ovf});
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("fifo_%0d", i));
    check("fifo_empty", {63'd0, rx_valid}, 64'd0);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // serialisation and underflow
    tx_load(32'hDEAD_BEEF);
    check("udf_before", {63'd0, underflow}, 64'd0);
    for (int i = 0; i < 4; i++) read_beat($sformatf("rd_%0d", i));
    check("tx_ready_after", {63'd0, tx_ready}, 64'd1);
    read_beat("rd_extra");
    check("udf_set", {63'd0, underflow}, 64'd1);

    // direction change discards the partial word
    tx_load(32'h1122_3344);
    beat(1'b0, 8'hEE);
    beat(1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) read_beat($sformatf("dir_rd_%0d", i));
    write_word(32'hAABB_CCDD);
    pop_one("dir_word");
    check("dir_single", {63'd0, rx_valid}, 64'd0);

    // mid-transfer reset
    core_done = 1'b1;
    beat(1'b0, 8'h55);
    beat(1'b0, 8'h66);
    tx_load(32'hCAFE_F00D);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_tx_ready", {63'd0, tx_ready}, 64'd1);
    check("mid_rst_data_out", {56'd0, bus_data_out}, 64'd0);
    check("mid_rst_flags", {60'd0, overflow, underflow, bus_done, rx_valid}, 64'd0);
    rx_sb.delete(); tx_sb.delete();
    model_cnt = 0; model_ovf = 1'b0; model_udf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    core_done = 1'b0;
    write_word(32'h0BAD_F00D);
    pop_one("post_rst_word");
    check("post_rst_ovf", {63'd0, overflow}, 64'd0);

    // status registers: one cycle latency
    @(negedge clk);
    core_done = 1'b1;
    core_match = 1'b1;
    #1;
    check("done_latency", {62'd0, bus_done, bus_match}, 64'd0);
    @(negedge clk);
    check("done_follow", {62'd0, bus_done, bus_match}, 64'd3);
    core_done = 1'b0;
    @(negedge clk);
    check("done_drop", {62'd0, bus_done, bus_match}, 64'd1);
    core_match = 1'b0;

    // 16/64 configuration
    w64 = 64'h0123_4567_89AB_CDEF;
    for (int b = 3; b >= 0; b--) beat16(w64[b*16 +: 16]);
    rx64_sb.push_back(w64);
    @(negedge clk);
    check("w64_valid", {63'd0, rx2_valid}, 64'd1);
    check("w64_data", rx2_data, rx64_sb.pop_front());
    rx2_ready = 1'b1;
    @(negedge clk);
    rx2_ready = 1'b0;
    check("w64_empty", {63'd0, rx2_valid}, 64'd0);

    w = '0;
    check("sb_drained", {32'd0, w + rx_sb.size() + tx_sb.size()}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/md5_par_bus_if.md
Name: md5_par_bus_if

Overview:
- Parametrised slave for the Raspberry Pi parallel bus, sitting between the board pins and the md5 core.
- Synchronises the asynchronous bus strobe and direction lines into the core clock domain.
- Writes: assembles BUS_WIDTH-bit beats into WORD_WIDTH-bit words, buffered in an RX FIFO for the core.
- Reads: serialises core result words back onto the bus, and registers the done/match status pins.

Parameters:
- BUS_WIDTH, 8, bus data width in bits.
- WORD_WIDTH, 32, core word width; must be an integer multiple of BUS_WIDTH (BEATS = WORD_WIDTH/BUS_WIDTH, BEATS >= 2).
- FIFO_DEPTH, 16, RX FIFO depth in words; power of two, >= 2.
- SYNC_STAGES, 2, synchroniser depth for bus_clk, bus_rnw and bus_data; >= 2.

Ports:
- clk  in  1  core clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- bus_clk  in  1  master strobe, asynchronous to clk.
- bus_rnw  in  1  1 = master reads, 0 = master writes.
- bus_data_in  in  BUS_WIDTH  pad input data.
- bus_data_out  out  BUS_WIDTH  pad output data.
- bus_data_oe  out  1  pad output enable.
- rx_data  out  WORD_WIDTH  assembled word to core.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  core pop.
- tx_data  in  WORD_WIDTH  result word from core.
- tx_valid  in  1  core offers word.
- tx_ready  out  1  TX shifter empty.
- core_done  in  1  core done status.
- core_match  in  1  core match status.
- bus_done  out  1  registered core_done.
- bus_match  out  1  registered core_match.
- overflow  out  1  sticky: word dropped on full FIFO.
- underflow  out  1  sticky: read beat with empty shifter.

Behaviour:
- Reset (async, active-high) values: all outputs 0 except tx_ready = 1. FIFO emptied, beat counters 0, synchronisers 0. Reset mid-word discards any partial word or shifter content.
- Synchronisers: bus_clk, bus_rnw and bus_data_in pass through identical SYNC_STAGES flop chains (rnw_s, data_s).
- Strobe: one-cycle strobe on a 0->1 transition of synchronised bus_clk, i.e. SYNC_STAGES+1 clk cycles after the pin edge.
- Master bus timing requirement: data and rnw stable for >= SYNC_STAGES+2 clk cycles around the rising edge.
- Write beat (strobe, rnw_s = 0):
  - data_s is placed MSB-first at beat index wr_cnt; wr_cnt increments.
  - On the last beat (wr_cnt = BEATS-1) the full word is pushed into the FIFO and wr_cnt wraps to 0.
  - Push while full with no simultaneous pop: word dropped, overflow set until reset.
  - Push while full with a simultaneous pop: push accepted.
- RX FIFO:
  - First-word-fall-through: rx_data is valid whenever rx_valid = 1.
  - Pop occurs on rx_valid & rx_ready.
  - A pushed word is visible on rx_valid on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- TX path:
  - Shifter loads on tx_valid & tx_ready; tx_ready drops on the next cycle; rd_cnt is set to BEATS.
  - bus_data_out = top BUS_WIDTH bits of the shifter.
  - Read beat (strobe, rnw_s = 1) with rd_cnt > 0: shift left by BUS_WIDTH, zero-fill, decrement rd_cnt. At rd_cnt = 0, tx_ready = 1.
  - Read beat with rd_cnt = 0: bus_data_out stays 0 and underflow is set.
- bus_data_oe = rnw_s, registered one cycle.
- Direction change: rnw_s 0->1 with wr_cnt != 0 discards the partial word and sets wr_cnt to 0. It does not set overflow.
- bus_done / bus_match: single-flop registers of core_done / core_match, one cycle latency.

Test Plan:
- Reset, then 4 write beats 0x01, 0x23, 0x45, 0x67 (8/32) -> rx_valid rises; rx_data = 0x01234567; after a pop, rx_valid = 0.
- 17 words written with rx_ready = 0, FIFO_DEPTH 16 -> 16 words retained in order; overflow = 1. Then pop all -> FIFO empties and overflow stays 1.
- tx_data = 0xDEADBEEF, tx_valid = 1, then 4 read beats -> bus_data_out presents DE, AD, BE, EF before each strobe; tx_ready = 1 after the 4th beat. A 5th beat -> underflow = 1, data 0x00.
- 2 write beats, rnw flipped to 1, 4 read beats, rnw back to 0, 4 write beats 0xAA..0xDD -> single word 0xAABBCCDD; no stale bytes.
- reset asserted after 2 write beats and after a tx load -> outputs return to reset values immediately; the next 4 beats form a clean word.
- core_done/core_match pulsed 1 -> bus_done/bus_match follow 1 clk later. With BUS_WIDTH = 16, WORD_WIDTH = 64, 4 beats -> correct 64-bit word.
